// File: rtl/hl2_tr_pkg.sv
// Shared state encoding, config payload and sizing helper for the T/R sequencer.
package hl2_tr_pkg;

   localparam int unsigned TICK_DIV_DEF    = 768;
   localparam int unsigned PRE_TICKS_DEF   = 2;
   localparam int unsigned DRAIN_TICKS_DEF = 1;
   localparam int unsigned HANG_W_DEF      = 8;

   typedef enum logic [2:0] {
      RX    = 3'd0,
      KEY   = 3'd1,
      TX    = 3'd2,
      UNKEY = 3'd3,
      HANG  = 3'd4
   } tr_state_e;

   typedef struct packed {
      logic pa;
      logic ext;
   } tr_cfg_t;

   // Prescaler width; a divide-by-one still needs a one-bit counter.
   function automatic int unsigned tick_w(input int unsigned div);
      return (div > 1) ? int'($clog2(div)) : 1;
   endfunction

endpackage

// File: rtl/tr_tick_timer.sv
// Tick prescaler plus saturating down-counter; done marks the final cycle of an N-tick wait.
module tr_tick_timer
   import hl2_tr_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF,
   parameter int unsigned CNT_W    = HANG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_load,
   output logic             o_done_c
);

   localparam int unsigned PW = tick_w(TICK_DIV);

   logic [PW-1:0]    r_pre;
   logic [CNT_W-1:0] r_rem;
   logic             w_wrap;

   assign w_wrap = (r_pre == PW'(TICK_DIV - 1));

   // Counter holds at zero once expired, so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre <= '0;
         r_rem <= '0;
      end else if (i_start) begin
         r_pre <= '0;
         r_rem <= i_load;
      end else if (r_rem != '0) begin
         if (w_wrap) begin
            r_pre <= '0;
            r_rem <= r_rem - CNT_W'(1);
         end else begin
            r_pre <= r_pre + PW'(1);
         end
      end
   end

   // A zero-length wait is done in its entry cycle.
   assign o_done_c = (r_rem == '0) || ((r_rem == CNT_W'(1)) && w_wrap);

endmodule

// File: rtl/tr_sequencer.sv
// Transmit/receive sequencer: keys relays before RF, drains RF before relays release.
module tr_sequencer
   import hl2_tr_pkg::*;
#(
   parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
   parameter int unsigned PRE_TICKS   = PRE_TICKS_DEF,
   parameter int unsigned DRAIN_TICKS = DRAIN_TICKS_DEF,
   parameter int unsigned HANG_W      = HANG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_req,
   input  logic              tx_inhibit,
   input  logic              pa_enable,
   input  logic              exttr_enable,
   input  logic [HANG_W-1:0] hang_ticks,
   output logic              rfsw_sel,
   output logic              pa_inttr,
   output logic              pa_exttr,
   output logic              txquiet_n,
   output logic              tx_active,
   output logic [2:0]        state_dbg
);

   tr_state_e         r_state;
   tr_state_e         w_next;
   tr_cfg_t           r_cfg;
   tr_cfg_t           w_cfg;
   logic              w_go;
   logic              w_start;
   logic              w_done;
   logic              w_keyed;
   logic              w_air;
   logic [HANG_W-1:0] w_load;
   logic              r_rfsw_sel;
   logic              r_pa_inttr;
   logic              r_pa_exttr;
   logic              r_txquiet_n;
   logic              r_tx_active;

   // Inhibit always wins over a key request.
   assign w_go = tx_req & ~tx_inhibit;

   always_comb begin
      w_next = r_state;
      w_cfg  = r_cfg;
      case (r_state)
         RX: begin
            if (w_go) begin
               w_next = KEY;
               w_cfg  = '{pa: pa_enable, ext: exttr_enable};
            end
         end
         KEY: begin
            if (!w_go)       w_next = HANG;
            else if (w_done) w_next = TX;
         end
         TX: begin
            if (!w_go) w_next = UNKEY;
         end
         UNKEY: begin
            if (w_done) w_next = HANG;
         end
         HANG: begin
            if (w_go)        w_next = TX;
            else if (w_done) w_next = RX;
         end
         default: w_next = RX;
      endcase
   end

   // Timer is reloaded with the wait length of whichever state is being entered.
   always_comb begin
      w_load = '0;
      case (w_next)
         KEY:     w_load = HANG_W'(PRE_TICKS);
         UNKEY:   w_load = HANG_W'(DRAIN_TICKS);
         HANG:    w_load = hang_ticks;
         default: w_load = '0;
      endcase
   end

   assign w_start = (w_next != r_state);
   assign w_keyed = (w_next != RX);
   assign w_air   = (w_next == TX);

   tr_tick_timer #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (HANG_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_start),
      .i_load   (w_load),
      .o_done_c (w_done)
   );

   // Outputs are decoded from the next state so they change in the same cycle as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RX;
         r_cfg       <= '0;
         r_rfsw_sel  <= 1'b0;
         r_pa_inttr  <= 1'b0;
         r_pa_exttr  <= 1'b0;
         r_txquiet_n <= 1'b0;
         r_tx_active <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cfg       <= w_cfg;
         r_rfsw_sel  <= w_keyed;
         r_pa_inttr  <= w_keyed & w_cfg.pa;
         r_pa_exttr  <= w_keyed & w_cfg.ext;
         r_txquiet_n <= w_air;
         r_tx_active <= w_air;
      end
   end

   assign rfsw_sel  = r_rfsw_sel;
   assign pa_inttr  = r_pa_inttr;
   assign pa_exttr  = r_pa_exttr;
   assign txquiet_n = r_txquiet_n;
   assign tx_active = r_tx_active;
   assign state_dbg = 3'(r_state);

endmodule

// File: tb/tb_tr_sequencer.sv
// Directed plus randomized bench for tr_sequencer against a cycle-count reference model.
module tb_tr_sequencer;

   localparam int TD    = 4;
   localparam int PRE   = 2;
   localparam int DRAIN = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_req;
   logic       tx_inhibit;
   logic       pa_enable;
   logic       exttr_enable;
   logic [7:0] hang_ticks;
   logic       rfsw_sel;
   logic       pa_inttr;
   logic       pa_exttr;
   logic       txquiet_n;
   logic       tx_active;
   logic [2:0] state_dbg;

   tr_sequencer #(
      .TICK_DIV    (TD),
      .PRE_TICKS   (PRE),
      .DRAIN_TICKS (DRAIN),
      .HANG_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_req       (tx_req),
      .tx_inhibit   (tx_inhibit),
      .pa_enable    (pa_enable),
      .exttr_enable (exttr_enable),
      .hang_ticks   (hang_ticks),
      .rfsw_sel     (rfsw_sel),
      .pa_inttr     (pa_inttr),
      .pa_exttr     (pa_exttr),
      .txquiet_n    (txquiet_n),
      .tx_active    (tx_active),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: phase plus remaining cycles in that phase.
   typedef enum {M_IDLE, M_PRE, M_AIR, M_DRAIN, M_HANG} mph_t;
   mph_t m_ph;
   int   m_left;
   logic m_pa, m_ext;
   logic prev_txq;
   logic [2:0] prev_rel;

   int cyc;
   int t_pa, t_on, t_off, t_rf;
   bit t_track;

   function automatic int dur(input int n);
      return (n == 0) ? 1 : n * TD;
   endfunction

   function automatic logic [31:0] ph_code(input mph_t p);
      case (p)
         M_IDLE:  return 32'd0;
         M_PRE:   return 32'd1;
         M_AIR:   return 32'd2;
         M_DRAIN: return 32'd3;
         default: return 32'd4;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph     = M_IDLE;
      m_left   = 0;
      m_pa     = 1'b0;
      m_ext    = 1'b0;
      prev_txq = 1'b0;
      prev_rel = 3'b000;
   endtask

   task automatic model_next();
      logic ok;
      ok = tx_req & ~tx_inhibit;
      case (m_ph)
         M_IDLE: if (ok) begin
            m_ph = M_PRE; m_left = dur(PRE); m_pa = pa_enable; m_ext = exttr_enable;
         end
         M_PRE: begin
            if (!ok) begin m_ph = M_HANG; m_left = dur(int'(hang_ticks)); end
            else if (m_left == 1) m_ph = M_AIR;
            else m_left--;
         end
         M_AIR: if (!ok) begin m_ph = M_DRAIN; m_left = dur(DRAIN); end
         M_DRAIN: begin
            if (m_left == 1) begin m_ph = M_HANG; m_left = dur(int'(hang_ticks)); end
            else m_left--;
         end
         default: begin
            if (ok) m_ph = M_AIR;
            else if (m_left == 1) m_ph = M_IDLE;
            else m_left--;
         end
      endcase
   endtask

   task automatic check_outputs();
      logic keyed, air;
      keyed = (m_ph != M_IDLE);
      air   = (m_ph == M_AIR);
      chk("rfsw_sel",  32'(rfsw_sel),  32'(keyed));
      chk("pa_inttr",  32'(pa_inttr),  32'(keyed & m_pa));
      chk("pa_exttr",  32'(pa_exttr),  32'(keyed & m_ext));
      chk("txquiet_n", 32'(txquiet_n), 32'(air));
      chk("tx_active", 32'(tx_active), 32'(air));
      chk("state_dbg", 32'(state_dbg), ph_code(m_ph));
      chk("inv_txq_implies_rfsw", 32'(txquiet_n & ~rfsw_sel), 32'd0);
      if (prev_txq && txquiet_n)
         chk("inv_relay_hold", 32'({rfsw_sel, pa_inttr, pa_exttr}), 32'(prev_rel));
      prev_txq = txquiet_n;
      prev_rel = {rfsw_sel, pa_inttr, pa_exttr};
   endtask

   task automatic step(input logic req, input logic inh, input logic pa, input logic ext,
                       input logic [7:0] hg);
      tx_req = req; tx_inhibit = inh; pa_enable = pa; exttr_enable = ext; hang_ticks = hg;
      model_next();
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      if (t_track) begin
         if (t_pa < 0 && pa_inttr) t_pa = cyc;
         if (t_on < 0 && txquiet_n) t_on = cyc;
         if (t_on >= 0 && t_off < 0 && !txquiet_n) t_off = cyc;
         if (t_off >= 0 && t_rf < 0 && !rfsw_sel) t_rf = cyc;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rfsw"}, 32'(rfsw_sel), 32'd0);
      chk({tag, "_inttr"}, 32'(pa_inttr), 32'd0);
      chk({tag, "_exttr"}, 32'(pa_exttr), 32'd0);
      chk({tag, "_txq"}, 32'(txquiet_n), 32'd0);
      chk({tag, "_txact"}, 32'(tx_active), 32'd0);
      chk({tag, "_state"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin
      logic req;
      rst = 1'b1; tx_req = 1'b0; tx_inhibit = 1'b0; pa_enable = 1'b0;
      exttr_enable = 1'b0; hang_ticks = 8'd0;
      cyc = 0; t_track = 1'b0; t_pa = -1; t_on = -1; t_off = -1; t_rf = -1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Basic key cycle with exact edge timing.
      cyc = 0; t_track = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
      for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
      t_track = 1'b0;
      chk("basic_pa_inttr_rise", 32'(t_pa),  32'd11);
      chk("basic_txq_rise",      32'(t_on),  32'd19);
      chk("basic_txq_fall",      32'(t_off), 32'd51);
      chk("basic_relay_fall",    32'(t_rf),  32'd67);

      // Re-key six cycles into hang: straight back to TX.
      for (int i = 0; i < 40 && m_ph != M_AIR; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'd20);
      chk("rekey_reach_tx", 32'(txquiet_n), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'd20);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'd20);
      chk("rekey_in_hang", 32'(state_dbg), 32'd4);
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'd20);
      chk("rekey_tx_state", 32'(state_dbg), 32'd2);
      chk("rekey_txq", 32'(txquiet_n), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'd20);

      // Inhibit during TX with tx_req held.
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
      chk("inhibit_txq_drop", 32'(txquiet_n), 32'd0);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
      chk("inhibit_back_rx", 32'(state_dbg), 32'd0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

      // Abort in KEY with zero hang.
      for (int i = 0; i < 100 && m_ph != M_IDLE; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("abort_idle_first", 32'(state_dbg), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("abort_hang", 32'(state_dbg), 32'd4);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("abort_zero_hang_rx", 32'(state_dbg), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

      // Asynchronous reset mid-TX, then a full PRE sequence again.
      for (int i = 0; i < 40 && m_ph != M_AIR; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
      chk("pre_reset_txq", 32'(txquiet_n), 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'd5);

      // Config toggles after latching are ignored.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'(i % 2), 1'(~i[0]), 8'd5);
      chk("cfg_latched_inttr", 32'(pa_inttr), 32'd1);
      chk("cfg_latched_exttr", 32'(pa_exttr), 32'd0);

      // Randomized traffic.
      req = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 7) == 0) req = ~req;
         step(req, 1'($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom),
              8'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
